// File: rtl/console_rx_port_pkg.sv
// console_rx_port_pkg: shared console address map, status bit positions and receiver states.
package console_rx_port_pkg;

    localparam logic [23:0] STDOUT_ADDR  = 24'hFFFFFE;
    localparam logic [23:0] STDIN_ADDR   = 24'hFFFFFE;
    localparam logic [23:0] STDSTAT_ADDR = 24'hFFFFFD;
    localparam logic [23:0] SIM_END_ADDR = 24'hFFFFFF;

    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/console_rx_port_rx_fifo.sv
// console_rx_port_rx_fifo: synchronous byte FIFO with combinational head read and occupancy count.
module console_rx_port_rx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];
    assign full    = count[AW];
    assign empty   = count == '0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/console_rx_port.sv
// console_rx_port: memory-mapped 8N1 console receiver with byte FIFO, status register and irq.
module console_rx_port
    import console_rx_port_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_AW      = 4,
    parameter logic [23:0] DATA_ADDR    = STDIN_ADDR,
    parameter logic [23:0] STAT_ADDR    = STDSTAT_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_rxd,
    input  logic [23:0] i_daddr,
    input  logic        i_rd,
    output logic [31:0] o_rdata,
    output logic        o_sel,
    output logic        o_irq
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic             rxd_m;
    logic             rxd_s;
    rx_state_t        state;
    rx_state_t        state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             push_req;
    logic             frame_set;
    logic             data_hit;
    logic             stat_hit;
    logic             rd_en;
    logic             pop;
    logic             push;
    logic             overrun_set;
    logic             overrun;
    logic             frame_err;
    logic [7:0]       head;
    logic             full;
    logic             empty;
    logic [FIFO_AW:0] count;
    logic [FIFO_AW:0] count_n;
    logic [3:0]       status;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rxd_m   <= 1'b1;
            rxd_s   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (i_clk_en) begin
            rxd_m   <= i_rxd;
            rxd_s   <= rxd_m;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // Start is confirmed at mid-bit; every later sample lands one full bit period on, near mid-bit.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = HALF_CNT;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (rxd_s) begin
                    state_n = IDLE;
                end else begin
                    state_n   = DATA;
                    cnt_n     = FULL_CNT;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    shreg_n   = {rxd_s, shreg[7:1]};
                    cnt_n     = FULL_CNT;
                    bit_idx_n = bit_idx + 3'd1;
                    state_n   = (bit_idx == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    state_n   = IDLE;
                    push_req  = i_clk_en & rxd_s;
                    frame_set = i_clk_en & ~rxd_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign data_hit    = i_daddr == DATA_ADDR;
    assign stat_hit    = i_daddr == STAT_ADDR;
    assign o_sel       = data_hit | stat_hit;
    assign rd_en       = i_rd & i_clk_en;
    assign pop         = rd_en & data_hit & ~empty;
    assign push        = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;
    assign count_n     = count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

    always_comb begin
        status                 = '0;
        status[STAT_NONEMPTY]  = ~empty;
        status[STAT_FULL]      = full;
        status[STAT_OVERRUN]   = overrun;
        status[STAT_FRAME_ERR] = frame_err;
    end

    console_rx_port_rx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A status read clears the sticky bits, but an event arriving in the same cycle keeps its bit set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata   <= '0;
            o_irq     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (i_clk_en) begin
            overrun   <= overrun_set | (overrun & ~(rd_en & stat_hit));
            frame_err <= frame_set | (frame_err & ~(rd_en & stat_hit));
            o_irq     <= count_n != '0;
            if (rd_en && data_hit)
                o_rdata <= empty ? 32'h0 : {23'b0, 1'b1, head};
            else if (rd_en && stat_hit)
                o_rdata <= {28'b0, status};
        end
    end

endmodule

// File: tb/tb_console_rx_port.sv
// tb_console_rx_port: randomized serial traffic against a queue-based console model.
module tb_console_rx_port;

    localparam int          CPB = 8;
    localparam logic [23:0] DA  = 24'hFFFFFE;
    localparam logic [23:0] SA  = 24'hFFFFFD;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        rxd;
    logic        rd;
    logic [23:0] daddr;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_ferr;
    bit         en_rand;
    int         n_cmp;
    int         n_err;

    console_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .i_rxd    (rxd),
        .i_daddr  (daddr),
        .i_rd     (rd),
        .o_rdata  (rdata),
        .o_sel    (sel),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        clk_en = 1'b1;
        forever begin
            @(negedge clk);
            clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_data();
        if (q.size() == 0) return 32'h0;
        return {23'b0, 1'b1, q.pop_front()};
    endfunction

    function automatic logic [31:0] m_stat();
        logic [31:0] s;
        s = {28'b0, m_ferr, m_ovr, q.size() == 16, q.size() != 0};
        m_ferr = 0;
        m_ovr  = 0;
        return s;
    endfunction

    function automatic void m_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1;
        else if (q.size() == 16) m_ovr = 1;
        else q.push_back(b);
    endfunction

    task automatic wait_en(input int n);
        repeat (n) begin
            do @(posedge clk); while (!clk_en);
        end
        #1;
    endtask

    task automatic do_read(input logic [23:0] a, output logic [31:0] d);
        daddr = a;
        rd    = 1'b1;
        wait_en(1);
        rd    = 1'b0;
        d     = rdata;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input bit rd_at_stop,
                             output logic [31:0] exp_rd, output logic [31:0] got_rd);
        exp_rd = 32'h0;
        got_rd = 32'h0;
        rxd = 1'b0;
        wait_en(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_en(CPB);
        end
        rxd = stop;
        if (rd_at_stop) begin
            wait_en(CPB - 2);
            exp_rd = m_data();
            daddr  = DA;
            rd     = 1'b1;
            wait_en(1);
            rd     = 1'b0;
            got_rd = rdata;
            wait_en(1);
        end else begin
            wait_en(CPB);
        end
        m_frame(b, stop);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; rd = 1'b0; daddr = '0; en_rand = 0;
        wait_en(3);
        n_cmp++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h want=%h", rdata, 32'h0); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", irq); end
        rst = 1'b0;
        wait_en(2);
    endtask

    task automatic test_sel();
        logic [23:0] addrs [4];
        addrs = '{DA, SA, 24'hFFFFFF, 24'h000000};
        foreach (addrs[i]) begin
            daddr = addrs[i];
            #1;
            n_cmp++;
            if (sel !== (addrs[i] == DA || addrs[i] == SA)) begin
                n_err++; $display("FAIL sel addr=%h got=%b want=%b", addrs[i], sel, (addrs[i] == DA || addrs[i] == SA));
            end
        end
        wait_en(1);
    endtask

    task automatic test_idle();
        logic [31:0] d, e;
        wait_en(40);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL idle_irq got=%b want=0", irq); end
        e = m_data(); do_read(DA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL idle_data got=%h want=%h", d, e); end
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL idle_stat got=%h want=%h", d, e); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, e;
        rxd = 1'b0;
        wait_en(2);
        rxd = 1'b1;
        wait_en(20);
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL glitch_stat got=%h want=%h", d, e); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got=%b want=0", irq); end
    endtask

    task automatic test_single();
        logic [31:0] d, e, x, y;
        send_byte(8'h41, 1'b1, 0, x, y);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq got=%b want=1", irq); end
        e = m_data(); do_read(DA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL single_data got=%h want=%h", d, e); end
        wait_en(1);
        n_cmp++;
        if (irq !== (q.size() != 0)) begin n_err++; $display("FAIL single_irq_clear got=%b want=%b", irq, q.size() != 0); end
    endtask

    task automatic test_overrun();
        logic [31:0] d, e, x, y;
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 0, x, y);
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL overrun_stat got=%h want=%h", d, e); end
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL overrun_stat_clear got=%h want=%h", d, e); end
        do_read(24'h000123, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL other_addr_hold got=%h want=%h", d, e); end
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL overrun_irq got=%b want=1", irq); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d, e, x, y;
        send_byte(8'hC3, 1'b1, 1, x, y);
        n_cmp++;
        if (y !== x) begin n_err++; $display("FAIL pushpop_data got=%h want=%h", y, x); end
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL pushpop_stat got=%h want=%h", d, e); end
        for (int i = 0; i < 17; i++) begin
            e = m_data(); do_read(DA, d);
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL drain_%0d got=%h want=%h", i, d, e); end
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d, e, x, y;
        send_byte(8'h55, 1'b0, 0, x, y);
        wait_en(2 * CPB);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL ferr_irq got=%b want=0", irq); end
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL ferr_stat got=%h want=%h", d, e); end
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL ferr_stat_clear got=%h want=%h", d, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e, x, y;
        send_byte(8'h5A, 1'b1, 0, x, y);
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL pre_reset_stat got=%h want=%h", d, e); end
        rxd = 1'b0;
        wait_en(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = ~i[0];
            wait_en(CPB);
        end
        rst = 1'b1;
        rxd = 1'b1;
        wait_en(2);
        q.delete(); m_ovr = 0; m_ferr = 0;
        n_cmp++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL midreset_rdata got=%h want=%h", rdata, 32'h0); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq got=%b want=0", irq); end
        rst = 1'b0;
        wait_en(12 * CPB);
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL midreset_stat got=%h want=%h", d, e); end
        e = m_data(); do_read(DA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL midreset_data got=%h want=%h", d, e); end
    endtask

    task automatic test_back_to_back(input bit rnd_en, input int n);
        logic [31:0] d, e, x, y;
        en_rand = rnd_en;
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1, 0, x, y);
        n_cmp++;
        if (irq !== (q.size() != 0)) begin n_err++; $display("FAIL b2b_irq en=%0d got=%b want=%b", rnd_en, irq, q.size() != 0); end
        e = m_stat(); do_read(SA, d);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL b2b_stat en=%0d got=%h want=%h", rnd_en, d, e); end
        for (int i = 0; i <= n; i++) begin
            e = m_data(); do_read(DA, d);
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL b2b_data en=%0d idx=%0d got=%h want=%h", rnd_en, i, d, e); end
        end
        en_rand = 0;
        wait_en(2);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sel();
        test_idle();
        test_glitch();
        test_single();
        test_overrun();
        test_push_pop_full();
        test_frame_err();
        test_reset_mid();
        test_back_to_back(1, 6);
        test_back_to_back(0, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
